bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares one 8-bit-address / 32-bit-data system bus between NUM_MASTERS bus masters (master 0 = testbench/CPU host, master 1 = DMAC) and the memory/slave side.
- Uses a req/grant handshake: round-robin arbitration, no preemption, registered grant.
- Routes the owning master's control, address and write data onto the shared bus, and broadcasts read data back to all masters.
- Sits between the DMAC's M_req/M_grant/M_address/M_wr/M_dout/M_din port group and the memory.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..4).
- AW, 8, address width.
- DW, 32, data width.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- M_req  in  NUM_MASTERS  per-master bus request; held high for the whole burst.
- M_wr  in  NUM_MASTERS  per-master write strobe (1 = write, 0 = read).
- M_address  in  NUM_MASTERS*AW  packed per-master address; master i occupies bits [i*AW +: AW].
- M_dout  in  NUM_MASTERS*DW  packed per-master write data.
- M_grant  out  NUM_MASTERS  registered one-hot grant.
- M_din  out  DW  read data broadcast to all masters (= Bus_rdata).
- Bus_sel  out  1  bus access valid.
- Bus_wr  out  1  bus write.
- Bus_address  out  AW  bus address.
- Bus_wdata  out  DW  bus write data.
- Bus_rdata  in  DW  read data from slave/memory.
- Owner  out  2  index of the current owner; valid only when Busy = 1.
- Busy  out  1  bus currently granted.

Behaviour:
- Reset (asynchronous, any time, including mid-burst) forces:
  - M_grant = 0, Busy = 0, Owner = 0, state IDLE.
  - last-owner pointer = NUM_MASTERS-1, so master 0 wins the first tie.
- FSM states:
  - IDLE: no grant. If any M_req is high, pick a winner round-robin, starting at (last+1) mod NUM_MASTERS and searching upward with wrap. Next edge: M_grant[winner] = 1, Owner = winner, last = winner, go to OWN.
  - OWN: grant is held unchanged while M_req[Owner] = 1. A waiting requester never preempts the owner (no timeout).
  - OWN, M_req[Owner] falls and another request is pending: re-arbitrate in the same cycle, starting at Owner+1. Next edge: grant moves directly to the new winner, with no idle bubble; state stays OWN.
  - OWN, M_req[Owner] falls and nothing else is pending: next edge M_grant = 0, go to IDLE.
- Latency:
  - Request to grant is 1 cycle minimum.
  - Release to handover is 1 cycle; the grant falls on the edge after req falls.
- M_grant is always one-hot or zero; it is never multi-hot.
- Bus mux is combinational from the registered Owner/Busy:
  - Bus_sel = Busy & M_req[Owner].
  - Bus_wr = Bus_sel & M_wr[Owner].
  - Bus_address and Bus_wdata come from the owner's slice.
  - When Bus_sel = 0: Bus_wr = 0, Bus_address = 0, Bus_wdata = 0, so there is no stray access in the release cycle.
- M_din = Bus_rdata unconditionally; only the granted master samples it.
- Requests from indices >= NUM_MASTERS do not exist. Owner is zero-extended.
- Owner request bouncing: if M_req[Owner] drops for a single cycle and then rises again, the arbiter treats the drop as a release. The master must re-arbitrate under normal round-robin.
- Busy = |M_grant.

Decomposition:
- Shared package bus_pkg:
  - AW/DW defaults.
  - FSM state encoding (IDLE = 1'b0, OWN = 1'b1).
  - MAX_MASTERS = 4.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: request vector, start index.
  - Outputs: found flag, winner index.
  - Used in both IDLE and OWN-release paths.
- Top bus_arbiter holds the FSM, the grant/owner/last registers and the bus mux.

Test Plan:
- Reset, then M_req = 2'b11 in the same cycle -> next edge M_grant = 01, Owner = 0. Master 0 drives addr 0x10, wdata 0xDEADBEEF, wr = 1 -> Bus_sel = 1, Bus_address = 0x10, Bus_wdata = 0xDEADBEEF.
- Master 0 drops req while master 1 is still requesting -> next edge M_grant = 10 with no zero-grant cycle. Bus_sel = 0 during the release cycle.
- Both masters request continuously, each releasing after 3 cycles -> grants alternate 01, 10, 01, 10. Each tenure lasts exactly 3 cycles of Bus_sel.
- Master 1 (DMAC) holds req for 20 cycles while master 0 requests from cycle 2 -> M_grant stays 10 for all 20 cycles. It switches to 01 one cycle after master 1 releases.
- Master 1 only: read burst with Bus_rdata = 0x12345678 -> M_din = 0x12345678 and Bus_wr = 0. Master 1 releases -> M_grant = 00, Busy = 0, state IDLE.
- reset_n pulsed low mid-burst while M_grant = 10 -> M_grant = 0 immediately, with no clock needed. After release with M_req = 11 -> master 0 is granted first.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the system bus arbiter.
//   DEFAULT_AW / DEFAULT_DW : default address and data widths
//   MAX_MASTERS             : upper bound on requesting masters (owner index is 2 bits)
//   arb_state_t             : arbiter FSM state encoding
package bus_pkg;

    localparam int DEFAULT_AW  = 8;
    localparam int DEFAULT_DW  = 32;
    localparam int MAX_MASTERS = 4;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector, one bit per master
//   start  : index searched first; the search moves upward and wraps
//   found  : at least one request is set
//   winner : first requesting index at or after start (modulo N)
module rr_pick
    import bus_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   start,
    output logic         found,
    output logic [1:0]   winner
);

    // Rotate the request vector so that bit 0 corresponds to 'start'.
    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] req_shift;
    logic [N-1:0]   rot;

    assign req_dbl   = {req, req};
    assign req_shift = req_dbl >> start;
    assign rot       = req_shift[N-1:0];

    // Priority chain over the rotated vector: the lowest set bit wins.
    logic [N:0]   taken;
    logic [N-1:0] hit;
    logic [1:0]   off_term [N];
    logic [1:0]   off_acc  [N+1];

    assign taken[0]   = 1'b0;
    assign off_acc[0] = 2'd0;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chain
            assign hit[gi]        = rot[gi] & ~taken[gi];
            assign taken[gi+1]    = taken[gi] | rot[gi];
            assign off_term[gi]   = hit[gi] ? 2'(gi) : 2'd0;
            assign off_acc[gi+1]  = off_acc[gi] | off_term[gi];
        end
    endgenerate

    // Map the rotated offset back to an absolute master index.
    logic [2:0] idx_sum;

    assign idx_sum = {1'b0, start} + {1'b0, off_acc[N]};
    assign found   = taken[N];
    assign winner  = (idx_sum >= 3'(N)) ? 2'(idx_sum - 3'(N)) : idx_sum[1:0];

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one system bus between
// NUM_MASTERS masters (0 = host CPU, 1 = DMAC) and the memory/slave side.
//   Clk, reset_n          : clock (rising edge) and asynchronous active-low reset
//   M_req / M_wr          : per-master request (held for the burst) and write strobe
//   M_address / M_dout    : packed per-master address and write data, master i at [i*W +: W]
//   M_grant               : registered one-hot grant
//   M_din                 : read data broadcast to every master
//   Bus_sel/Bus_wr/Bus_address/Bus_wdata : shared bus, driven from the owner's slice
//   Bus_rdata             : read data from the slave side
//   Owner / Busy          : current owner index (valid when Busy) and grant-active flag
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = DEFAULT_AW,
    parameter int DW          = DEFAULT_DW
) (
    input  logic                      Clk,
    input  logic                      reset_n,
    input  logic [NUM_MASTERS-1:0]    M_req,
    input  logic [NUM_MASTERS-1:0]    M_wr,
    input  logic [NUM_MASTERS*AW-1:0] M_address,
    input  logic [NUM_MASTERS*DW-1:0] M_dout,
    output logic [NUM_MASTERS-1:0]    M_grant,
    output logic [DW-1:0]             M_din,
    output logic                      Bus_sel,
    output logic                      Bus_wr,
    output logic [AW-1:0]             Bus_address,
    output logic [DW-1:0]             Bus_wdata,
    input  logic [DW-1:0]             Bus_rdata,
    output logic [1:0]                Owner,
    output logic                      Busy
);

    arb_state_t             state_reg, state_next;
    logic [NUM_MASTERS-1:0] grant_reg, grant_next;
    logic [1:0]             owner_reg, owner_next;
    logic [1:0]             last_reg,  last_next;

    logic       pick_found;
    logic [1:0] pick_winner;
    logic [1:0] pick_start;
    logic [NUM_MASTERS-1:0] win_onehot;
    logic       owner_req;

    // While owning, last == owner, so one picker starting at last+1 serves
    // both the idle arbitration and the release handover. The releasing
    // owner's own request is low, so it cannot re-win in the same cycle.
    assign pick_start = (last_reg == 2'(NUM_MASTERS-1)) ? 2'd0 : last_reg + 2'd1;

    rr_pick #(
        .N (NUM_MASTERS)
    ) u_pick (
        .req    (M_req),
        .start  (pick_start),
        .found  (pick_found),
        .winner (pick_winner)
    );

    // Grant is one-hot, so masking with it selects the owner's request.
    assign owner_req = |(grant_reg & M_req);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_onehot
            assign win_onehot[gi] = (pick_winner == 2'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    grant_next = win_onehot;
                    owner_next = pick_winner;
                    last_next  = pick_winner;
                    state_next = OWN;
                end
            end
            OWN: begin
                if (!owner_req) begin
                    if (pick_found) begin
                        grant_next = win_onehot;
                        owner_next = pick_winner;
                        last_next  = pick_winner;
                    end else begin
                        grant_next = '0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                grant_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            owner_reg <= 2'd0;
            last_reg  <= 2'(NUM_MASTERS-1);
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
        end
    end

    // Bus mux: a master's slice passes only while it is granted and still
    // requesting, so the release cycle produces an all-zero bus.
    logic [NUM_MASTERS-1:0] sel_vec;
    logic [AW-1:0] addr_acc  [NUM_MASTERS+1];
    logic [DW-1:0] wdata_acc [NUM_MASTERS+1];

    assign sel_vec      = grant_reg & M_req;
    assign addr_acc[0]  = '0;
    assign wdata_acc[0] = '0;

    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_mux
            assign addr_acc[gi+1]  = addr_acc[gi]  |
                (sel_vec[gi] ? M_address[gi*AW +: AW] : {AW{1'b0}});
            assign wdata_acc[gi+1] = wdata_acc[gi] |
                (sel_vec[gi] ? M_dout[gi*DW +: DW] : {DW{1'b0}});
        end
    endgenerate

    assign Bus_sel     = |sel_vec;
    assign Bus_wr      = |(sel_vec & M_wr);
    assign Bus_address = addr_acc[NUM_MASTERS];
    assign Bus_wdata   = wdata_acc[NUM_MASTERS];

    assign M_grant = grant_reg;
    assign M_din   = Bus_rdata;
    assign Owner   = owner_reg;
    assign Busy    = |grant_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed scenarios followed by randomized
// request traffic, checked against a behavioural round-robin model.
module tb_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = 8;
    localparam int DW = 32;

    logic            Clk;
    logic            reset_n;
    logic [N-1:0]    M_req;
    logic [N-1:0]    M_wr;
    logic [N*AW-1:0] M_address;
    logic [N*DW-1:0] M_dout;
    logic [N-1:0]    M_grant;
    logic [DW-1:0]   M_din;
    logic            Bus_sel;
    logic            Bus_wr;
    logic [AW-1:0]   Bus_address;
    logic [DW-1:0]   Bus_wdata;
    logic [DW-1:0]   Bus_rdata;
    logic [1:0]      Owner;
    logic            Busy;

    bus_arbiter #(
        .NUM_MASTERS (N),
        .AW          (AW),
        .DW          (DW)
    ) dut (
        .Clk         (Clk),
        .reset_n     (reset_n),
        .M_req       (M_req),
        .M_wr        (M_wr),
        .M_address   (M_address),
        .M_dout      (M_dout),
        .M_grant     (M_grant),
        .M_din       (M_din),
        .Bus_sel     (Bus_sel),
        .Bus_wr      (Bus_wr),
        .Bus_address (Bus_address),
        .Bus_wdata   (Bus_wdata),
        .Bus_rdata   (Bus_rdata),
        .Owner       (Owner),
        .Busy        (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int cycle_cnt = 0;

    // Reference model: who holds the bus (-1 = nobody) and who held it last.
    int exp_own;
    int exp_last;

    // Random traffic state per master.
    int hold_left [N];
    int gap_left  [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle_cnt);
        end
    endtask

    task automatic model_reset();
        exp_own  = -1;
        exp_last = N - 1;
    endtask

    // Ownership is kept while the owner requests; otherwise the bus goes to
    // the first requester found counting upward from the last owner.
    task automatic model_update();
        int prev;
        int found;
        int c;
        prev = exp_own;
        if (!reset_n) begin
            model_reset();
        end else if (!(exp_own >= 0 && M_req[exp_own])) begin
            found = -1;
            for (int k = 1; k <= N; k++) begin
                c = (exp_last + k) % N;
                if (found < 0 && M_req[c]) found = c;
            end
            exp_own = found;
            if (found >= 0) exp_last = found;
        end
        if (exp_own != prev)
            $display("cycle %0d: grant %0d -> %0d", cycle_cnt, prev, exp_own);
    endtask

    task automatic check_all();
        logic [N-1:0]  e_grant;
        logic          e_sel;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        e_grant = '0;
        e_sel   = 1'b0;
        if (exp_own >= 0) begin
            e_grant[exp_own] = 1'b1;
            e_sel = M_req[exp_own];
        end
        e_wr    = e_sel ? M_wr[exp_own] : 1'b0;
        e_addr  = e_sel ? M_address[exp_own*AW +: AW] : '0;
        e_wdata = e_sel ? M_dout[exp_own*DW +: DW] : '0;
        chk("grant", 64'(M_grant), 64'(e_grant));
        chk("busy", 64'(Busy), 64'(exp_own >= 0));
        if (exp_own >= 0) chk("owner", 64'(Owner), 64'(exp_own));
        chk("bus_sel", 64'(Bus_sel), 64'(e_sel));
        chk("bus_wr", 64'(Bus_wr), 64'(e_wr));
        chk("bus_addr", 64'(Bus_address), 64'(e_addr));
        chk("bus_wdata", 64'(Bus_wdata), 64'(e_wdata));
        chk("m_din", 64'(M_din), 64'(Bus_rdata));
    endtask

    // One clock: model follows the edge, outputs are checked on the falling edge.
    task automatic tick();
        @(posedge Clk);
        cycle_cnt++;
        model_update();
        @(negedge Clk);
        check_all();
    endtask

    initial begin
        reset_n   = 1'b0;
        M_req     = '0;
        M_wr      = '0;
        M_address = '0;
        M_dout    = '0;
        Bus_rdata = '0;
        model_reset();

        // Reset state.
        #2;
        chk("rst_grant", 64'(M_grant), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_owner", 64'(Owner), 64'd0);
        @(negedge Clk);
        reset_n = 1'b1;

        // Both request together: master 0 wins the first tie.
        M_req     = 2'b11;
        M_wr      = 2'b01;
        M_address = {8'h20, 8'h10};
        M_dout    = {32'hCAFEF00D, 32'hDEADBEEF};
        tick();
        $display("step: tie after reset, grant=%b", M_grant);
        chk("tie_grant", 64'(M_grant), 64'h1);
        chk("tie_addr", 64'(Bus_address), 64'h10);
        chk("tie_wdata", 64'(Bus_wdata), 64'hDEADBEEF);
        chk("tie_wr", 64'(Bus_wr), 64'd1);

        // Master 0 releases while master 1 waits: quiet release cycle, direct handover.
        M_req = 2'b10;
        #1;
        chk("rel_sel", 64'(Bus_sel), 64'd0);
        chk("rel_addr", 64'(Bus_address), 64'd0);
        tick();
        $display("step: handover, grant=%b", M_grant);
        chk("handover", 64'(M_grant), 64'h2);

        // DMAC holds for 20 cycles, host requests from cycle 2: no preemption.
        tick();
        M_req = 2'b11;
        for (int i = 0; i < 18; i++) begin
            tick();
            chk("no_preempt", 64'(M_grant), 64'h2);
        end
        M_req = 2'b01;
        tick();
        $display("step: dmac release, grant=%b", M_grant);
        chk("after_dmac", 64'(M_grant), 64'h1);
        M_req = 2'b00;
        tick();

        // DMAC read burst.
        M_req     = 2'b10;
        M_wr      = 2'b00;
        Bus_rdata = 32'h12345678;
        tick();
        tick();
        $display("step: dmac read, m_din=%h", M_din);
        chk("rd_din", 64'(M_din), 64'h12345678);
        chk("rd_wr", 64'(Bus_wr), 64'd0);
        chk("rd_sel", 64'(Bus_sel), 64'd1);
        M_req = 2'b00;
        tick();
        chk("rd_idle_grant", 64'(M_grant), 64'd0);
        chk("rd_idle_busy", 64'(Busy), 64'd0);

        // Asynchronous reset mid-burst.
        M_req = 2'b10;
        tick();
        chk("pre_rst_grant", 64'(M_grant), 64'h2);
        #1;
        reset_n = 1'b0;
        #1;
        $display("step: async reset, grant=%b", M_grant);
        chk("async_rst_grant", 64'(M_grant), 64'd0);
        chk("async_rst_busy", 64'(Busy), 64'd0);
        model_reset();
        tick();
        reset_n = 1'b1;
        M_req   = 2'b11;
        tick();
        chk("post_rst_tie", 64'(M_grant), 64'h1);

        // Randomized traffic; a one-cycle gap exercises request bouncing.
        M_req = 2'b00;
        tick();
        for (int i = 0; i < N; i++) begin
            hold_left[i] = 0;
            gap_left[i]  = int'($urandom_range(1, 4));
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (M_req[i]) begin
                    if (exp_own == i) begin
                        if (hold_left[i] <= 1) begin
                            M_req[i]    = 1'b0;
                            gap_left[i] = int'($urandom_range(1, 4));
                        end else begin
                            hold_left[i]--;
                        end
                    end
                end else begin
                    gap_left[i]--;
                    if (gap_left[i] <= 0) begin
                        M_req[i]     = 1'b1;
                        hold_left[i] = int'($urandom_range(1, 5));
                    end
                end
            end
            M_wr      = N'($urandom);
            M_address = {N{8'h00}} | (N*AW)'({$urandom, $urandom});
            M_dout    = {$urandom, $urandom};
            Bus_rdata = $urandom;
            #1;
            check_all();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
